// File: rtl/rv_div_seq_if.sv
// Request/response bundle between the ALU (master) and the sequential divider (slave).
interface rv_div_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            rdy;
  logic            req;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output rdy, req, op, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  rdy, req, op, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/rv_div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU with a done pulse and busy stall.
// Define RV_DIV_BYPASS_EN to reuse the last result when operands and signedness repeat.
module rv_div_seq #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BITS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  rv_div_seq_if.slave bus
);
  localparam int unsigned Steps = XLEN / BITS_PER_CYC;
  localparam int unsigned CntW  = $clog2(Steps);
  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, d_q, r_q, q_q, result_q;
  logic [CntW-1:0] cnt_q;
  logic            qneg_q, rneg_q, busy_q, done_q;

  logic            accept, hit, op_signed, div0, ovf;
  logic [XLEN-1:0] a_abs, b_abs, sp_quo, sp_rem, quo_fix, rem_fix, hit_result;
  logic [XLEN-1:0] step_r, step_q, step_d, nr, nq;
  logic [XLEN:0]   trial, diff;

  assign accept    = bus.req & bus.rdy & ((state_q == StIdle) | (state_q == StDone));
  assign op_signed = ~op_q[0];
  assign a_abs     = (op_signed & a_q[XLEN-1]) ? -a_q : a_q;
  assign b_abs     = (op_signed & b_q[XLEN-1]) ? -b_q : b_q;
  assign div0      = (b_q == '0);
  assign ovf       = op_signed & (a_q == IntMin) & (b_q == '1);
  assign sp_quo    = div0 ? '1 : IntMin;
  assign sp_rem    = div0 ? a_q : '0;
  assign quo_fix   = qneg_q ? -q_q : q_q;
  assign rem_fix   = rneg_q ? -r_q : r_q;

  // PREP retires the first step straight from the abs operands, so only Steps-1 ITER
  // cycles follow and accept-to-done stays at 2 + Steps.
  always_comb begin
    step_r = (state_q == StPrep) ? '0    : r_q;
    step_q = (state_q == StPrep) ? a_abs : q_q;
    step_d = (state_q == StPrep) ? b_abs : d_q;
    nr     = step_r;
    nq     = step_q;
    trial  = '0;
    diff   = '0;
    for (int unsigned i = 0; i < BITS_PER_CYC; i++) begin
      trial = {nr, nq[XLEN-1]};
      diff  = trial - {1'b0, step_d};
      nq    = {nq[XLEN-2:0], ~diff[XLEN]};
      nr    = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

`ifdef RV_DIV_BYPASS_EN
  logic            tag_valid_q, tag_signed_q;
  logic [XLEN-1:0] tag_rs1_q, tag_rs2_q, tag_quo_q, tag_rem_q;

  assign hit = tag_valid_q & (bus.rs1 == tag_rs1_q) & (bus.rs2 == tag_rs2_q) &
               (~bus.op[0] == tag_signed_q);
  assign hit_result = bus.op[1] ? tag_rem_q : tag_quo_q;

  // Operands are captured at accept; the tag only becomes valid once the op completes,
  // so a reset mid-operation leaves it invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q  <= 1'b0;
      tag_signed_q <= 1'b0;
      tag_rs1_q    <= '0;
      tag_rs2_q    <= '0;
      tag_quo_q    <= '0;
      tag_rem_q    <= '0;
    end else if (accept & ~hit) begin
      tag_valid_q  <= 1'b0;
      tag_signed_q <= ~bus.op[0];
      tag_rs1_q    <= bus.rs1;
      tag_rs2_q    <= bus.rs2;
    end else if (state_q == StFix) begin
      tag_valid_q <= 1'b1;
      tag_quo_q   <= quo_fix;
      tag_rem_q   <= rem_fix;
    end else if ((state_q == StPrep) & (div0 | ovf)) begin
      tag_valid_q <= 1'b1;
      tag_quo_q   <= sp_quo;
      tag_rem_q   <= sp_rem;
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.rs1;
            b_q  <= bus.rs2;
            if (hit) begin
              state_q  <= StDone;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= hit_result;
            end else begin
              state_q <= StPrep;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else if ((state_q == StDone) & bus.rdy) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        StPrep: begin
          if (div0 | ovf) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= op_q[1] ? sp_rem : sp_quo;
          end else begin
            state_q <= StIter;
            r_q     <= nr;
            q_q     <= nq;
            d_q     <= b_abs;
            cnt_q   <= CntW'(Steps - 1);
            qneg_q  <= op_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
            rneg_q  <= op_signed & a_q[XLEN-1];
          end
        end
        StIter: begin
          r_q   <= nr;
          q_q   <= nq;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          state_q  <= StDone;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= op_q[1] ? rem_fix : quo_fix;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_rv_div_seq.sv
// Scoreboard bench for rv_div_seq: directed cases plus random ops against a / % model.
module tb_rv_div_seq;
  localparam int unsigned XLEN = 32;
  localparam int unsigned BPC  = 1;

  typedef struct {
    logic [31:0] exp;
    int          cyc;
    int          lat;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t e;

  bit          m_valid;
  logic [31:0] m_a, m_b;
  bit          m_sgn;

  rv_div_seq_if #(.XLEN(XLEN)) bus ();

  rv_div_seq #(
    .XLEN        (XLEN),
    .BITS_PER_CYC(BPC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit chk, input string nm, output int c);
    bit   sgn, special;
    int   lat;
    exp_t x;
    sgn     = ~op[0];
    special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    lat     = special ? 2 : 2 + int'(XLEN / BPC);
`ifdef RV_DIV_BYPASS_EN
    if (m_valid && m_a == a && m_b == b && m_sgn == sgn) lat = 1;
`endif
    m_valid = 1'b1;
    m_a     = a;
    m_b     = b;
    m_sgn   = sgn;
    c       = cyc;
    x.exp   = ref_model(op, a, b);
    x.cyc   = cyc;
    x.lat   = chk ? lat : -1;
    x.nm    = nm;
    sb_q.push_back(x);
    bus.rdy = 1'b1;
    bus.req = 1'b1;
    bus.op  = op;
    bus.rs1 = a;
    bus.rs2 = b;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'd0;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every DONE cycle with rdy=1 retires exactly one op.
  always @(negedge clk) begin
    if (!reset && bus.done && bus.rdy) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %h with no op outstanding", bus.result);
      end else begin
        e = sb_q.pop_front();
        check(e.nm, bus.result, e.exp);
        if (e.lat >= 0) check({e.nm, "_lat"}, cyc - e.cyc, e.lat);
      end
    end
  end

  initial begin
    int c, n;
    logic [1:0]  rop;
    logic [31:0] ra, rb, pa, pb;
    reset   = 1'b1;
    bus.rdy = 1'b1;
    bus.req = 1'b0;
    bus.op  = 2'b00;
    bus.rs1 = 32'd0;
    bus.rs2 = 32'd0;
    m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full-latency op with busy window probes
    issue(2'b01, 32'd100, 32'd7, 1'b1, "divu_100_7", c);
    check("t1_busy_c1", {31'b0, bus.busy}, 32'd1);
    wait_cyc(c + 33);
    check("t1_busy_c33", {31'b0, bus.busy}, 32'd1);
    check("t1_done_c33", {31'b0, bus.done}, 32'd0);
    wait_cyc(c + 34);
    check("t1_busy_c34", {31'b0, bus.busy}, 32'd0);
    wait_idle();
    issue(2'b11, 32'd100, 32'd7, 1'b1, "remu_100_7", c);
    wait_idle();

    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2", c);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, "rem_m7_2", c);
    wait_idle();
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2", c);
    wait_idle();

    issue(2'b00, 32'd5, 32'd0, 1'b1, "div_5_0", c);
    wait_idle();
    issue(2'b11, 32'd5, 32'd0, 1'b1, "remu_5_0", c);
    wait_idle();
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf", c);
    wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "rem_ovf", c);
    wait_idle();

    // Stray req while busy, then hold rdy low across DONE
    issue(2'b01, 32'd50, 32'd5, 1'b0, "divu_hold", c);
    wait_cyc(c + 5);
    bus.req = 1'b1;
    bus.op  = 2'b01;
    bus.rs1 = 32'd77;
    bus.rs2 = 32'd2;
    wait_cyc(c + 8);
    bus.req = 1'b0;
    wait_cyc(c + 10);
    bus.rdy = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_lat", cyc - c, 32'd34);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", {31'b0, bus.done}, 32'd1);
      check("hold_result", bus.result, ref_model(2'b01, 32'd50, 32'd5));
    end
    bus.rdy = 1'b1;
    @(posedge clk);
    #1;
    check("hold_exit_done", {31'b0, bus.done}, 32'd0);
    check("hold_exit_busy", {31'b0, bus.busy}, 32'd0);
    wait_idle();

    // Reset mid-ITER aborts without a done
    issue(2'b01, 32'd1234, 32'd5, 1'b1, "divu_abort", c);
    wait_cyc(c + 10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    sb_q.delete();
    m_valid = 1'b0;
    reset   = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b01, 32'd9, 32'd3, 1'b1, "divu_9_3", c);
    wait_idle();

    issue(2'b00, 32'd1000, 32'd3, 1'b1, "div_1000_3", c);
    wait_idle();
    issue(2'b10, 32'd1000, 32'd3, 1'b1, "rem_1000_3", c);
    wait_idle();

    pa = 32'd0;
    pb = 32'd0;
    for (int k = 0; k < 150; k++) begin
      rop = 2'($urandom_range(0, 3));
      if (k > 0 && $urandom_range(0, 7) == 0) begin
        ra = pa;
        rb = pb;
      end else begin
        ra = pick();
        rb = pick();
      end
      issue(rop, ra, rb, 1'b1, "rand", c);
      wait_idle();
      pa = ra;
      pb = rb;
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
